trailer_sequencer: RTL and testbench
====================================

// Module: trailer_sequencer
// PURPOSE
//  Upstream controller for the full-screen trailer graphics unit (320x240, 3-bit colour).
//  Issues one-cycle plot pulses to the unit, waits for each full-screen draw to finish,
//  then holds that image on screen for a fixed time.
//  Alternates the 1-bit frame select on every draw, repeats for a set number of loops,
//  then reports completion to the top-level game FSM.
//  A skip input ends the trailer early, but never while a frame is only partly drawn.
// PARAMETERS
//  FRAME_TICKS  12_500_000  clk cycles to hold each drawn frame (0.25 s at 50 MHz); must be >= 1
//  LOOPS        4           number of frame-0/frame-1 pairs shown; total draws = 2*LOOPS; must be >= 1
// PORTS
//  clk           in   1   system clock
//  resetn        in   1   asynchronous active-low reset
//  start         in   1   level; sampled only in IDLE; starts a trailer run
//  skip          in   1   level; requests early end of the run
//  gu_done       in   1   done from the graphics unit; only its rising edge is used
//  plot          out  1   one-cycle pulse that starts one full-screen draw
//  frame         out  1   frame select to the graphics unit; stable from plot until the next draw
//  busy          out  1   high in every state except IDLE
//  trailer_done  out  1   one-cycle pulse when a run ends (normal end or skip)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE; plot=0, frame=0, busy=0, trailer_done=0.
//   - Hold counter=0, draw counter=0, skip_pending=0, gu_done edge register=0.
//  Edge detect: done_rise = gu_done & ~gu_done_q; gu_done_q is registered every cycle.
//  States:
//   - IDLE: on start=1, go to DRAW; frame=0, draw counter=0.
//   - DRAW: plot=1 for exactly this cycle; then go to WAIT.
//   - WAIT: stay until done_rise.
//       If skip_pending=1 or skip=1, go to FIN.
//       Otherwise load hold counter=FRAME_TICKS-1 and go to HOLD.
//       skip=1 seen here sets skip_pending, so the current draw always completes.
//   - HOLD: decrement the hold counter each cycle.
//       skip=1 on any cycle goes to FIN on the next cycle.
//       At counter==0, go to NEXT.
//   - NEXT: if draw counter==2*LOOPS-1, go to FIN.
//       Otherwise toggle frame, increment draw counter, go to DRAW.
//   - FIN: trailer_done=1 for this cycle; clear skip_pending; frame=0; go to IDLE.
//  Latency:
//   - start to plot: 1 cycle.
//   - Frame on screen: FRAME_TICKS cycles of HOLD, plus NEXT, then the next plot.
//  Rules:
//   - start is ignored while busy; skip is ignored in IDLE.
//   - If start and skip are both high in IDLE, the run starts; skip then ends it after the first draw.
//   - gu_done already high when the run starts produces no rise and does not advance WAIT.
//   - Counter widths come from $clog2; the hold counter never underflows.
//   - Async reset mid-run returns to IDLE immediately; the graphics unit is reset by the same resetn.
//  All outputs are registered or decoded from the state register only; there are no input-to-output combinational paths.
// STRUCTURE
//  Shared include trailer_defs.vh:
//   - state encoding localparams (IDLE, DRAW, WAIT, HOLD, NEXT, FIN; 3 bits);
//   - SCREEN_W=320, SCREEN_H=240.
//  One sub-module: hold_timer, a loadable down-counter with zero flag, parameterised by FRAME_TICKS.
//  The FSM, draw counter, skip latch and edge detector sit in trailer_sequencer.
// TESTING (bench: FRAME_TICKS=4, LOOPS=2; gu_done model rises 10 cycles after plot, falls on the next plot)
//  1. Reset, then start=1 for 1 cycle:
//     - 4 plot pulses; frame sequence 0,1,0,1.
//     - 4 cycles of HOLD after each done_rise.
//     - trailer_done pulses once; busy falls in the same cycle that the state returns to IDLE.
//  2. skip=1 for 1 cycle during the 2nd HOLD: no 3rd plot; trailer_done 1 cycle later; frame=0.
//  3. skip=1 during the 3rd WAIT:
//     - the draw completes (done_rise seen);
//     - then FIN with no HOLD and no 4th plot.
//  4. gu_done held high before start:
//     - WAIT does not advance until gu_done falls and rises again;
//     - then the normal sequence follows.
//  5. start pulsed while busy: no extra plot, draw count unchanged; plot total is still 4.
//  6. resetn asserted mid-HOLD: all outputs 0 asynchronously; after release, a new start runs a full 4-draw sequence.

Source files
------------

// File: rtl/trailer_sequencer_pkg.sv
// Shared types, constants and helpers for the trailer sequencer.
package trailer_sequencer_pkg;

    // Geometry of the full-screen trailer image drawn by the graphics unit.
    localparam int unsigned SCREEN_W = 320;
    localparam int unsigned SCREEN_H = 240;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_DRAW = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_NEXT = 3'd4,
        ST_FIN  = 3'd5
    } state_e;

    // Width of a counter that must hold values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trailer_sequencer_hold_timer.sv
// Loadable down-counter that times how long a drawn frame stays on screen.
module trailer_sequencer_hold_timer
    import trailer_sequencer_pkg::*;
#(
    parameter int unsigned FRAME_TICKS = 12_500_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic dec,
    output logic zero_c
);

    localparam int unsigned CNT_W = cnt_width(FRAME_TICKS);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(FRAME_TICKS - 1);

    logic [CNT_W-1:0] cnt_q;

    // Load takes priority; decrement saturates at zero so the count never wraps.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/trailer_sequencer.sv
// Drives the trailer graphics unit: plot, wait for draw, hold, alternate frames, report done.
module trailer_sequencer
    import trailer_sequencer_pkg::*;
#(
    parameter int unsigned FRAME_TICKS = 12_500_000,
    parameter int unsigned LOOPS       = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic skip,
    input  logic gu_done,
    output logic plot,
    output logic frame,
    output logic busy,
    output logic trailer_done
);

    localparam int unsigned DRAWS  = 2 * LOOPS;
    localparam int unsigned DRAW_W = cnt_width(DRAWS);
    localparam logic [DRAW_W-1:0] LAST_DRAW = DRAW_W'(DRAWS - 1);

    state_e            state_q;
    state_e            state_d;
    logic              gu_done_q;
    logic              done_rise_c;
    logic              skip_pend_q;
    logic              skip_pend_d;
    logic              frame_d;
    logic [DRAW_W-1:0] draw_cnt_q;
    logic [DRAW_W-1:0] draw_cnt_d;
    logic              timer_load;
    logic              timer_dec;
    logic              timer_zero_c;

    // Only a fresh rising edge of gu_done counts; a level left over from a previous draw is ignored.
    assign done_rise_c = gu_done & ~gu_done_q;

    trailer_sequencer_hold_timer #(
        .FRAME_TICKS (FRAME_TICKS)
    ) u_hold_timer (
        .clk    (clk),
        .resetn (resetn),
        .load   (timer_load),
        .dec    (timer_dec),
        .zero_c (timer_zero_c)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        skip_pend_d = skip_pend_q;
        frame_d     = frame;
        draw_cnt_d  = draw_cnt_q;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_DRAW;
                    frame_d    = 1'b0;
                    draw_cnt_d = '0;
                end
            end
            ST_DRAW: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A skip during a draw is remembered so the image is never cut off half-drawn.
                if (skip) begin
                    skip_pend_d = 1'b1;
                end
                if (done_rise_c) begin
                    if (skip_pend_q || skip) begin
                        state_d = ST_FIN;
                    end else begin
                        timer_load = 1'b1;
                        state_d    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                timer_dec = 1'b1;
                if (skip) begin
                    state_d = ST_FIN;
                end else if (timer_zero_c) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (draw_cnt_q == LAST_DRAW) begin
                    state_d = ST_FIN;
                end else begin
                    frame_d    = ~frame;
                    draw_cnt_d = draw_cnt_q + DRAW_W'(1);
                    state_d    = ST_DRAW;
                end
            end
            ST_FIN: begin
                skip_pend_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame select reads 0 from the moment the run finishes.
        if (state_d == ST_FIN) begin
            frame_d = 1'b0;
        end
    end

    // Datapath registers: edge detector, skip latch, frame select and draw counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gu_done_q   <= 1'b0;
            skip_pend_q <= 1'b0;
            frame       <= 1'b0;
            draw_cnt_q  <= '0;
        end else begin
            gu_done_q   <= gu_done;
            skip_pend_q <= skip_pend_d;
            frame       <= frame_d;
            draw_cnt_q  <= draw_cnt_d;
        end
    end

    // Registered state decodes, so each output is valid for exactly the cycle its state is held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            plot         <= 1'b0;
            busy         <= 1'b0;
            trailer_done <= 1'b0;
        end else begin
            plot         <= (state_d == ST_DRAW);
            busy         <= (state_d != ST_IDLE);
            trailer_done <= (state_d == ST_FIN);
        end
    end

    // Pulse and busy invariants.
    a_plot_pulse : assert property (@(posedge clk) disable iff (!resetn) plot |=> !plot);
    a_done_pulse : assert property (@(posedge clk) disable iff (!resetn) trailer_done |=> !trailer_done);
    a_plot_busy  : assert property (@(posedge clk) disable iff (!resetn) plot |-> busy);

endmodule

// File: tb/tb_trailer_sequencer.sv
// Scoreboard bench for trailer_sequencer with FRAME_TICKS=4, LOOPS=2.
module tb_trailer_sequencer;

    typedef struct packed {
        logic        is_done;
        logic        frm;
        logic [31:0] at;
    } ev_t;

    logic clk     = 1'b0;
    logic resetn  = 1'b0;
    logic start   = 1'b0;
    logic skip    = 1'b0;
    logic gu_done = 1'b0;
    logic plot;
    logic frame;
    logic busy;
    logic trailer_done;

    int unsigned cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    ev_t exp_q[$];
    bit  busy_chk   = 1'b0;
    bit  stall_mode = 1'b0;
    int  rise_cnt   = 0;
    int  fall_cnt   = 0;

    trailer_sequencer #(
        .FRAME_TICKS (4),
        .LOOPS       (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .skip         (skip),
        .gu_done      (gu_done),
        .plot         (plot),
        .frame        (frame),
        .busy         (busy),
        .trailer_done (trailer_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Graphics unit model: done falls on plot and rises 10 cycles later.
    // In stall mode done sits high and, after a plot, falls at +5 and rises at +15.
    always @(negedge clk) begin
        if (!resetn) begin
            gu_done  = 1'b0;
            rise_cnt = 0;
            fall_cnt = 0;
        end else if (plot) begin
            if (stall_mode) begin
                fall_cnt = 5;
                rise_cnt = 15;
            end else begin
                gu_done  = 1'b0;
                rise_cnt = 10;
            end
        end else begin
            if (fall_cnt > 0) begin
                fall_cnt--;
                if (fall_cnt == 0) gu_done = 1'b0;
            end
            if (rise_cnt > 0) begin
                rise_cnt--;
                if (rise_cnt == 0) gu_done = 1'b1;
            end
            if (stall_mode && fall_cnt == 0 && rise_cnt == 0) gu_done = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every plot/done pulse against the scoreboard; checks outputs under reset.
    always @(negedge clk or negedge resetn) begin
        ev_t e;
        if (!resetn) begin
            #1;
            check("reset_outputs", {28'd0, plot, frame, busy, trailer_done}, 32'd0);
        end else begin
            if (busy_chk) begin
                check("busy_after_done", {31'd0, busy}, 32'd0);
                busy_chk = 1'b0;
            end
            if (plot || trailer_done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: plot=%0b done=%0b at cycle %0d, nothing expected",
                             plot, trailer_done, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check(e.is_done ? "done_kind" : "plot_kind", {30'd0, plot, trailer_done},
                          e.is_done ? 32'd1 : 32'd2);
                    check("event_cycle", cyc, e.at);
                    check("event_frame", {31'd0, frame}, {31'd0, e.frm});
                    check("event_busy", {31'd0, busy}, 32'd1);
                    if (trailer_done) busy_chk = 1'b1;
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].at) begin
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL missing_event: %s expected at cycle %0d, still absent at cycle %0d",
                         e.is_done ? "done" : "plot", e.at, cyc);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) step();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic push(input logic d, input logic f, input int unsigned at);
        exp_q.push_back('{is_done: d, frm: f, at: at});
    endtask

    task automatic push_full(input int unsigned p0, input int unsigned gap);
        push(1'b0, 1'b0, p0);
        push(1'b0, 1'b1, p0 + gap);
        push(1'b0, 1'b0, p0 + gap + 16);
        push(1'b0, 1'b1, p0 + gap + 32);
        push(1'b1, 1'b0, p0 + gap + 48);
    endtask

    // Pulses start for one cycle and pushes the expected pulse schedule for the chosen scenario.
    task automatic start_run(input int mode, output int unsigned p0);
        step();
        start = 1'b1;
        p0 = cyc + 1;
        case (mode)
            0: push_full(p0, 16);
            1: push_full(p0, 21);
            2: begin
                push(1'b0, 1'b0, p0);
                push(1'b0, 1'b1, p0 + 16);
                push(1'b1, 1'b0, p0 + 29);
            end
            3: begin
                push(1'b0, 1'b0, p0);
                push(1'b0, 1'b1, p0 + 16);
                push(1'b0, 1'b0, p0 + 32);
                push(1'b1, 1'b0, p0 + 43);
            end
            4: begin
                push(1'b0, 1'b0, p0);
                push(1'b0, 1'b1, p0 + 16);
            end
            default: begin
                push(1'b0, 1'b0, p0);
                push(1'b1, 1'b0, p0 + 11);
            end
        endcase
        step();
        start = 1'b0;
    endtask

    task automatic drain();
        while (exp_q.size() != 0) step();
        idle(20);
    endtask

    initial begin
        int unsigned p0;
        repeat (3) @(negedge clk);
        #1 resetn = 1'b1;
        idle(3);

        // Full run: four draws, frames 0,1,0,1, then one done pulse.
        start_run(0, p0);
        drain();

        // Skip during the second hold.
        start_run(2, p0);
        wait_until(p0 + 28);
        skip = 1'b1;
        step();
        skip = 1'b0;
        drain();

        // Skip during the third wait: that draw completes, then finish without hold.
        start_run(3, p0);
        wait_until(p0 + 36);
        skip = 1'b1;
        step();
        skip = 1'b0;
        drain();

        // gu_done already high at start: only a fresh rise advances WAIT.
        stall_mode = 1'b1;
        idle(3);
        start_run(1, p0);
        wait_until(p0 + 2);
        stall_mode = 1'b0;
        drain();

        // start pulses while busy are ignored.
        start_run(0, p0);
        wait_until(p0 + 20);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_until(p0 + 40);
        start = 1'b1;
        step();
        start = 1'b0;
        drain();

        // Async reset in the second hold, then a fresh full run.
        start_run(4, p0);
        wait_until(p0 + 28);
        exp_q.delete();
        resetn = 1'b0;
        idle(3);
        resetn = 1'b1;
        idle(3);
        start_run(0, p0);
        drain();

        // skip alone in IDLE is ignored; start with skip high ends after the first draw.
        skip = 1'b1;
        idle(5);
        start_run(5, p0);
        drain();
        skip = 1'b0;
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

endmodule
